bitstream_self_write_loader: RTL
================================

Name: bitstream_self_write_loader

Overview:
Configuration sequencer for the eFPGA fabric's self-write configuration port. It reads a byte-wide bitstream from a synchronous memory and packs each group of 4 bytes into a big-endian 32-bit word. Each word is presented on SelfWriteData with programmable setup and hold spacing around a one-cycle SelfWriteStrobe. It sits between an on-chip bitstream ROM/RAM and the fabric's SelfWriteData/SelfWriteStrobe inputs, and replaces bench-driven loading in emulation/self-boot builds.

Parameters:
ADDR_WIDTH, 14, byte address width of bitstream memory (16384 bytes).
SETUP_CYCLES, 2, cycles SelfWriteData is stable before the strobe (min 1).
HOLD_CYCLES, 2, cycles SelfWriteData is held after the strobe (min 1).

Ports:
CLK  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a load; sampled in IDLE only.
byte_count  in  ADDR_WIDTH+1  bitstream length in bytes; latched on accepted start.
abort  in  1  terminates an in-progress load.
mem_addr  out  ADDR_WIDTH  byte read address.
mem_rd  out  1  read enable; mem_data is valid on the cycle after mem_rd.
mem_data  in  8  read data.
SelfWriteData  out  32  configuration word to fabric.
SelfWriteStrobe  out  1  one-cycle write strobe to fabric.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Clock is CLK. reset is synchronous and active-high.
- Reset values: state IDLE; SelfWriteData=0, SelfWriteStrobe=0, mem_rd=0, mem_addr=0, busy=0, done=0, internal byte pointer=0.
- States: IDLE, FETCH, SETUP, STROBE, HOLD, FINISH.
- IDLE: when start=1, latch byte_count and clear the pointer.
  - byte_count=0: go to FINISH.
  - Otherwise: go to FETCH.
- FETCH: lasts exactly 5 cycles (f=0..4).
  - Cycles f=0..3: drive mem_addr=ptr+f. Assert mem_rd only when ptr+f < latched count.
  - Cycles f=1..4: capture the byte from the previous cycle's read into lane 3-(f-1). Lane 3 is bits [31:24], so the word is {b0,b1,b2,b3}.
  - A lane whose address is >= count is filled with 8'h00 and no read is issued for it.
  - End of f=4: copy the assembled word to SelfWriteData, advance ptr by 4, go to SETUP.
- SelfWriteData changes only at the FETCH->SETUP edge. It is stable through SETUP, STROBE and HOLD.
- SETUP: SETUP_CYCLES cycles, then STROBE.
- STROBE: exactly 1 cycle with SelfWriteStrobe=1, then HOLD. SelfWriteStrobe is 0 in all other states.
- HOLD: HOLD_CYCLES cycles.
  - If ptr >= count, go to FINISH.
  - Otherwise, go to FETCH.
- FINISH: 1 cycle with done=1, then IDLE.
- Per-word period is 6+SETUP_CYCLES+HOLD_CYCLES cycles (10 at defaults).
- Word count is ceil(count/4). The final partial word is zero-padded in its low lanes.
- start while busy: ignored.
- abort=1 in any non-IDLE state: next state IDLE.
  - No done pulse. mem_rd deasserts next cycle. SelfWriteData retains its last value.
  - If abort coincides with the STROBE cycle, that strobe has already been issued and counts as written.
- abort in IDLE has no effect. When start and abort are both high in IDLE, start wins.
- reset mid-operation: returns to IDLE with reset values, no done pulse.
- Pointer arithmetic is ADDR_WIDTH+1 bits wide, so byte_count = 2^ADDR_WIDTH is legal with no wrap. byte_count > 2^ADDR_WIDTH is clamped to 2^ADDR_WIDTH at latch.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum, out, 32 bits.
  - checksum is the modulo-2^32 sum of every word strobed since the last accepted start. It is updated in the STROBE cycle and visible from the next cycle.
  - Cleared by reset and by an accepted start.
  - Retained after done or abort.
- Undefined: no checksum port and no adder logic. All other behaviour is identical.

Test Plan:
- Memory bytes 00..07 = 01 02 03 04 05 06 07 08, byte_count=8, start pulse -> two strobes with SelfWriteData 0x01020304 then 0x05060708. Strobes are 10 cycles apart, done pulses once, busy drops together with done.
- byte_count=6, same memory -> second word 0x05060000. mem_rd is never asserted for addresses 6 and 7.
- byte_count=0 -> done pulses in the cycle after start, with zero strobes and zero mem_rd.
- Load of byte_count=16 with abort asserted in SETUP of word 2 -> exactly 1 strobe, no done, busy low next cycle. A later start of byte_count=4 works normally.
- start pulsed again while busy, and reset asserted mid-FETCH -> the extra start has no effect. After reset all outputs are 0 and the state is IDLE.
- With LOADER_CHECKSUM_EN defined, 8-byte case -> checksum = 0x0608_0A0C after the second strobe. A new start clears it to 0.

Source files
------------

// File: rtl/bitstream_self_write_loader.sv
// Self-write configuration loader: packs bytes from a synchronous bitstream memory into big-endian
// 32-bit words and strobes them into the fabric. Define LOADER_CHECKSUM_EN to add a running word checksum.
module bitstream_self_write_loader #(
    parameter int ADDR_WIDTH   = 14,
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   byte_count,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_data,
    output logic [31:0]           SelfWriteData,
    output logic                  SelfWriteStrobe,
    output logic                  busy,
    output logic                  done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int CW = $clog2(SETUP_CYCLES + HOLD_CYCLES + 6) + 1;
    localparam logic [CW-1:0] FETCH_LAST = CW'(4);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] MAX_COUNT  = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   count_q;
    logic [31:0]     word_q;
    logic            rd_q;
    logic [PW-1:0]   count_clamped;
    logic [PW-1:0]   addr_full;
    logic [7:0]      byte_in;

    assign count_clamped = (byte_count > MAX_COUNT) ? MAX_COUNT : byte_count;
    assign addr_full     = ptr_q + PW'(cnt_q[2:0]);
    // Lanes past the end of the bitstream were never read, so they pad with zero.
    assign byte_in       = rd_q ? mem_data : 8'h00;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        busy            = 1'b0;
        done            = 1'b0;
        SelfWriteStrobe = 1'b0;
        mem_rd          = 1'b0;
        mem_addr        = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (count_clamped == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (cnt_q != FETCH_LAST) begin
                    mem_addr = addr_full[ADDR_WIDTH-1:0];
                    mem_rd   = (addr_full < count_q);
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                SelfWriteStrobe = 1'b1;
                state_d         = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = (ptr_q >= count_q) ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE) begin
            busy = 1'b1;
            if (abort) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q         <= '0;
            ptr_q         <= '0;
            count_q       <= '0;
            word_q        <= '0;
            rd_q          <= 1'b0;
            SelfWriteData <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            rd_q  <= mem_rd;
            cnt_q <= (state_d == state_q && state_q != S_IDLE) ? cnt_q + 1'b1 : '0;
            if (state_q == S_IDLE && start) begin
                count_q  <= count_clamped;
                ptr_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
                checksum <= '0;
`endif
            end
            // Each FETCH cycle 1..4 captures the byte requested one cycle earlier, MSB lane first.
            if (state_q == S_FETCH) begin
                case (cnt_q)
                    CW'(1):  word_q[31:24] <= byte_in;
                    CW'(2):  word_q[23:16] <= byte_in;
                    CW'(3):  word_q[15:8]  <= byte_in;
                    CW'(4):  word_q[7:0]   <= byte_in;
                    default: ;
                endcase
            end
            if (state_q == S_FETCH && state_d == S_SETUP) begin
                SelfWriteData <= {word_q[31:8], byte_in};
                ptr_q         <= ptr_q + PW'(4);
            end
`ifdef LOADER_CHECKSUM_EN
            if (state_q == S_STROBE) begin
                checksum <= checksum + SelfWriteData;
            end
`endif
        end
    end

endmodule
